// File: rtl/soma_completo_behav_if.sv
// Operand/result bundle for the ripple adder leaf cell.
// The master drives operands; the slave returns the result.
interface soma_completo_behav_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, a, b, carry_in,
    input  sum, carry_out, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, carry_in,
    output sum, carry_out, overflow, out_valid
  );
endinterface

// File: rtl/soma_completo_behav.sv
// WIDTH-bit ripple full adder with optional output register.
// Carry chain is bit-serial; overflow is carry-into-MSB ^ carry-out.
module soma_completo_behav #(
  parameter int WIDTH      = 1,
  parameter bit REGISTERED = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  soma_completo_behav_if.slave bus
);

  logic [WIDTH-1:0] s_c;
  logic             co_c;
  logic             ov_c;
  logic             vld_q;

  // Ripple carry chain, one full-adder cell per bit
  always_comb begin : ripple
    logic cy;
    logic c_msb;
    cy    = bus.carry_in;
    c_msb = 1'b0;
    s_c   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c_msb  = cy;
      s_c[i] = bus.a[i] ^ bus.b[i] ^ cy;
      cy     = (bus.a[i] & bus.b[i]) |
               (bus.a[i] & cy) |
               (bus.b[i] & cy);
    end
    co_c = cy;
    ov_c = c_msb ^ cy;
  end

  // Result-valid flag is always one cycle behind in_valid
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= bus.in_valid;
  end

  assign bus.out_valid = vld_q;

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ov_q;

    // Capture on accepted operands; hold while the bus is idle
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        co_q  <= 1'b0;
        ov_q  <= 1'b0;
      end else if (bus.in_valid) begin
        sum_q <= s_c;
        co_q  <= co_c;
        ov_q  <= ov_c;
      end
    end

    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
  end else begin : g_comb
    assign bus.sum       = s_c;
    assign bus.carry_out = co_c;
    assign bus.overflow  = ov_c;
  end

endmodule

// File: tb/tb_soma_completo_behav.sv
// Directed and random checks of the ripple adder cell
// in 1-, 8-, 16-bit registered and 1-bit combinational forms.
module tb_soma_completo_behav;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  soma_completo_behav_if #(.WIDTH(1))  b1 ();
  soma_completo_behav_if #(.WIDTH(8))  b8 ();
  soma_completo_behav_if #(.WIDTH(1))  b0 ();
  soma_completo_behav_if #(.WIDTH(16)) b16 ();

  soma_completo_behav #(.WIDTH(1), .REGISTERED(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  soma_completo_behav #(.WIDTH(8), .REGISTERED(1'b1)) u8 (
    .clk(clk), .rst(rst), .bus(b8)
  );
  soma_completo_behav #(.WIDTH(1), .REGISTERED(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  soma_completo_behav #(.WIDTH(16), .REGISTERED(1'b1)) u16 (
    .clk(clk), .rst(rst), .bus(b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic exp_s [8];
  logic exp_c [8];
  logic [17:0] hold;
  logic [17:0] nxt;
  logic [16:0] full;
  logic        vld;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rc;
  logic [15:0] rs;

  initial begin
    checks = 0;
    errors = 0;
    exp_s = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.carry_in = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.carry_in = 1'b0;
    b0.in_valid = 1'b0; b0.a = '0; b0.b = '0; b0.carry_in = 1'b0;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.carry_in = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_sum", 64'(b1.sum), 64'd0);
    chk("rst_co", 64'(b1.carry_out), 64'd0);
    chk("rst_ov", 64'(b1.overflow), 64'd0);
    chk("rst_vld", 64'(b1.out_valid), 64'd0);
    chk("rst_sum8", 64'(b8.sum), 64'd0);
    rst = 1'b0;
    tick();

    // 1-bit truth table, a=bit2 b=bit1 cin=bit0
    for (int v = 0; v < 8; v++) begin
      logic [2:0] t;
      t = 3'(v);
      b1.a = t[2];
      b1.b = t[1];
      b1.carry_in = t[0];
      b1.in_valid = 1'b1;
      tick();
      chk($sformatf("tt%0d_sum", v), 64'(b1.sum), 64'(exp_s[v]));
      chk($sformatf("tt%0d_co", v), 64'(b1.carry_out), 64'(exp_c[v]));
      chk($sformatf("tt%0d_ov", v), 64'(b1.overflow),
          64'(t[0] ^ exp_c[v]));
      chk($sformatf("tt%0d_vld", v), 64'(b1.out_valid), 64'd1);
    end

    // reset wins over simultaneous in_valid
    b1.a = 1'b1; b1.b = 1'b1; b1.carry_in = 1'b1; b1.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    chk("rstpri_sum", 64'(b1.sum), 64'd0);
    chk("rstpri_co", 64'(b1.carry_out), 64'd0);
    chk("rstpri_vld", 64'(b1.out_valid), 64'd0);
    rst = 1'b0;
    tick();
    chk("after_rst_sum", 64'(b1.sum), 64'd1);
    chk("after_rst_co", 64'(b1.carry_out), 64'd1);
    chk("after_rst_ov", 64'(b1.overflow), 64'd0);
    chk("after_rst_vld", 64'(b1.out_valid), 64'd1);

    // hold while idle, even with X on the bus
    b1.a = 1'b1; b1.b = 1'b0; b1.carry_in = 1'b0; b1.in_valid = 1'b1;
    tick();
    chk("cap_sum", 64'(b1.sum), 64'd1);
    b1.in_valid = 1'b0;
    b1.a = 1'b0; b1.b = 1'b1; b1.carry_in = 1'b1;
    tick();
    chk("hold_sum", 64'(b1.sum), 64'd1);
    chk("hold_co", 64'(b1.carry_out), 64'd0);
    chk("hold_vld", 64'(b1.out_valid), 64'd0);
    b1.a = 1'bx; b1.b = 1'bx; b1.carry_in = 1'bx;
    tick();
    chk("holdx_sum", 64'(b1.sum), 64'd1);
    chk("holdx_co", 64'(b1.carry_out), 64'd0);
    chk("holdx_ov", 64'(b1.overflow), 64'd0);
    b1.a = 1'b0; b1.b = 1'b0; b1.carry_in = 1'b0;

    // 8-bit boundary vectors, back to back
    b8.in_valid = 1'b1;
    b8.a = 8'hFF; b8.b = 8'h01; b8.carry_in = 1'b0;
    tick();
    chk("w8a_sum", 64'(b8.sum), 64'h00);
    chk("w8a_co", 64'(b8.carry_out), 64'd1);
    chk("w8a_ov", 64'(b8.overflow), 64'd0);
    b8.a = 8'h7F; b8.b = 8'h01; b8.carry_in = 1'b0;
    tick();
    chk("w8b_sum", 64'(b8.sum), 64'h80);
    chk("w8b_co", 64'(b8.carry_out), 64'd0);
    chk("w8b_ov", 64'(b8.overflow), 64'd1);
    b8.a = 8'hFF; b8.b = 8'hFF; b8.carry_in = 1'b1;
    tick();
    chk("w8c_sum", 64'(b8.sum), 64'hFF);
    chk("w8c_co", 64'(b8.carry_out), 64'd1);
    chk("w8c_ov", 64'(b8.overflow), 64'd0);
    chk("w8c_vld", 64'(b8.out_valid), 64'd1);
    b8.a = 8'h80; b8.b = 8'h80; b8.carry_in = 1'b0;
    tick();
    chk("w8d_sum", 64'(b8.sum), 64'h00);
    chk("w8d_co", 64'(b8.carry_out), 64'd1);
    chk("w8d_ov", 64'(b8.overflow), 64'd1);
    b8.in_valid = 1'b0;

    // combinational form: outputs move with no clock edge
    b0.a = 1'b0; b0.b = 1'b1; b0.carry_in = 1'b1;
    #1;
    chk("comb0_sum", 64'(b0.sum), 64'd0);
    chk("comb0_co", 64'(b0.carry_out), 64'd1);
    #1;
    b0.a = 1'b1; b0.b = 1'b0; b0.carry_in = 1'b0;
    #1;
    chk("comb1_sum", 64'(b0.sum), 64'd1);
    chk("comb1_co", 64'(b0.carry_out), 64'd0);
    chk("comb1_ov", 64'(b0.overflow), 64'd0);
    chk("comb1_vld", 64'(b0.out_valid), 64'd0);
    b0.in_valid = 1'b1;
    tick();
    chk("comb_vld_hi", 64'(b0.out_valid), 64'd1);
    b0.in_valid = 1'b0;
    tick();
    chk("comb_vld_lo", 64'(b0.out_valid), 64'd0);

    // 16-bit random stream against a sign-rule reference
    hold = '0;
    for (int n = 0; n < 1000; n++) begin
      vld = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (n % 97 == 5) begin
        ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1;
      end
      b16.in_valid = vld;
      b16.a = ra;
      b16.b = rb;
      b16.carry_in = rc;
      full = 17'(ra) + 17'(rb) + 17'(rc);
      rs = full[15:0];
      nxt = {(ra[15] == rb[15]) && (rs[15] != ra[15]), full};
      if (vld) hold = nxt;
      tick();
      chk($sformatf("rnd%0d_res", n),
          64'({b16.overflow, b16.carry_out, b16.sum}), 64'(hold));
      chk($sformatf("rnd%0d_vld", n), 64'(b16.out_valid), 64'(vld));
    end
    b16.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soma_completo_behav.md
Name: soma_completo_behav

Overview:
Behavioural full adder, generalised to a WIDTH-bit ripple adder with registered outputs. Adds operands a and b plus carry_in and produces sum and carry_out. With WIDTH=1 it is the classic 1-bit full adder. Used as the arithmetic leaf cell in the circuit-6 datapath, or chained through carry_in/carry_out for wider adders.

Parameters:
WIDTH, 1, operand and sum width in bits (legal range 1..64).
REGISTERED, 1, 1 = outputs registered (1-cycle latency); 0 = combinational outputs, and clk/rst affect only out_valid.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands valid this cycle; result captured when high.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
carry_in  input  1  carry into bit 0.
sum  output  WIDTH  (a + b + carry_in) mod 2^WIDTH.
carry_out  output  1  carry out of bit WIDTH-1.
overflow  output  1  signed overflow, defined as carry into MSB XOR carry_out.
out_valid  output  1  sum/carry_out/overflow hold a fresh result.

Behaviour:
- Per-bit equations, with c[0] = carry_in:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
- carry_out = c[WIDTH]; overflow = c[WIDTH-1] ^ c[WIDTH].
- Ripple structure, no carry lookahead required.
- Full unsigned result = {carry_out, sum} = a + b + carry_in. Its maximum, 2^(WIDTH+1) - 1, must never be truncated.
- REGISTERED=1:
  - On a rising edge with in_valid=1, register sum, carry_out and overflow from the current inputs; out_valid <= 1 on the next cycle.
  - With in_valid=0, the result registers hold their previous values and out_valid <= 0.
  - Latency is exactly 1 cycle. Back-to-back in_valid gives one result per cycle.
- REGISTERED=0:
  - sum, carry_out and overflow follow the inputs combinationally, with zero latency regardless of in_valid.
  - out_valid is the registered in_valid (1-cycle delayed).
- Reset (rst=1 at a rising edge):
  - sum=0, carry_out=0, overflow=0, out_valid=0.
  - Reset has priority over a simultaneous in_valid; that operand is dropped.
  - Reset mid-stream discards the in-flight result.
- After reset deasserts, the first in_valid produces out_valid one cycle later.
- No X propagation from an idle bus: with in_valid=0 the outputs must not change, even if a/b/carry_in are X.
- Only unsigned semantics are defined for carry_out. overflow is informational, for two's-complement users.
- With WIDTH=1, overflow = c[0] ^ c[1] = carry_in ^ carry_out.

Test Plan:
1. WIDTH=1, REGISTERED=1: apply all 8 combinations of (a,b,carry_in) in order 000..111, one per cycle with in_valid=1 → results one cycle later are (sum,carry_out) = (0,0), (1,0), (1,0), (0,1), (1,0), (0,1), (0,1), (1,1).
2. Reset: drive a=1, b=1, carry_in=1 with in_valid=1 and rst=1 on the same edge → sum=0, carry_out=0, out_valid=0. Deassert rst and reapply → sum=1, carry_out=1, out_valid=1 after 1 cycle.
3. Hold: capture a=1, b=0, cin=0 (sum=1), then drop in_valid and toggle the inputs → sum stays 1, carry_out stays 0, out_valid=0.
4. WIDTH=8: a=0xFF, b=0x01, cin=0 → sum=0x00, carry_out=1, overflow=0. Then a=0x7F, b=0x01, cin=0 → sum=0x80, carry_out=0, overflow=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, carry_out=1.
5. REGISTERED=0, WIDTH=1: change inputs mid-cycle from 011 to 100 → sum 0→1 and carry_out 1→0 with no clock edge.
6. Random stream, WIDTH=16, 1000 cycles with in_valid toggling randomly → {carry_out,sum} equals a+b+cin of the matching accepted input, checked against a reference model.
